// File: rtl/ccr_cond_resolver.sv
// Conditional-execute resolver: decides commit/squash for IF_CARRY/IF_ZERO instructions
// from CCR flags, counting in-flight flag writers and stalling until the flags are final.
module ccr_cond_resolver #(
  parameter int TAG_W    = 4,
  parameter int PEND_MAX = 3
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            issue_valid,
  output logic                            issue_ready,
  input  logic [1:0]                      issue_cond,
  input  logic                            issue_setflag,
  input  logic [TAG_W-1:0]                issue_tag,
  input  logic                            ccr_carry,
  input  logic                            ccr_zero,
  input  logic                            flag_wr_valid,
  input  logic                            flag_wr_carry,
  input  logic                            flag_wr_zero,
  input  logic                            flush,
  output logic                            res_valid,
  output logic                            res_pass,
  output logic [TAG_W-1:0]                res_tag,
  output logic [$clog2(PEND_MAX+1)-1:0]   pend_cnt,
  output logic                            err_underflow
);

  localparam int CNT_W = $clog2(PEND_MAX + 1);

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic [1:0] {
    COND_ALWAYS = 2'b00,
    COND_CARRY  = 2'b01,
    COND_ZERO   = 2'b10,
    COND_NEVER  = 2'b11
  } cond_t;

  state_t             state, next_state;
  logic [1:0]         held_cond;
  logic               held_setflag;
  logic [TAG_W-1:0]   held_tag;

  logic               dec, inc, rslv, accept, latch, res_fire, res_pass_d;
  logic               eff_carry, eff_zero;
  logic [TAG_W-1:0]   res_tag_d;
  logic [CNT_W-1:0]   pend_after_dec;

  // A flag write landing this edge is forwarded so the dependent instruction
  // resolves in the same cycle the write retires.
  assign eff_carry      = flag_wr_valid ? flag_wr_carry : ccr_carry;
  assign eff_zero       = flag_wr_valid ? flag_wr_zero  : ccr_zero;
  assign dec            = flag_wr_valid && (pend_cnt != '0);
  assign rslv           = (pend_cnt == '0) || ((pend_cnt == CNT_W'(1)) && flag_wr_valid);
  assign pend_after_dec = pend_cnt - CNT_W'(dec);

  function automatic logic eval_cond(input logic [1:0] c, input logic cy, input logic z);
    case (cond_t'(c))
      COND_ALWAYS: eval_cond = 1'b1;
      COND_CARRY:  eval_cond = cy;
      COND_ZERO:   eval_cond = z;
      default:     eval_cond = 1'b0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    next_state  = state;
    issue_ready = 1'b0;
    accept      = 1'b0;
    latch       = 1'b0;
    res_fire    = 1'b0;
    res_pass_d  = 1'b0;
    res_tag_d   = '0;
    inc         = 1'b0;
    case (state)
      S_IDLE: begin
        issue_ready = !(issue_setflag && (pend_after_dec == CNT_W'(PEND_MAX)));
        accept      = issue_valid && issue_ready;
        if (accept) begin
          if (cond_t'(issue_cond) == COND_ALWAYS || cond_t'(issue_cond) == COND_NEVER || rslv) begin
            res_fire   = 1'b1;
            res_pass_d = eval_cond(issue_cond, eff_carry, eff_zero);
            res_tag_d  = issue_tag;
            inc        = issue_setflag;
          end else begin
            latch      = 1'b1;
            next_state = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (flush) begin
          next_state = S_IDLE;
        end else if (rslv) begin
          res_fire   = 1'b1;
          res_pass_d = eval_cond(held_cond, eff_carry, eff_zero);
          res_tag_d  = held_tag;
          inc        = held_setflag;
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: all state below updates with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      held_cond     <= 2'b00;
      held_setflag  <= 1'b0;
      held_tag      <= '0;
      res_valid     <= 1'b0;
      res_pass      <= 1'b0;
      res_tag       <= '0;
      pend_cnt      <= '0;
      err_underflow <= 1'b0;
    end else begin
      state     <= next_state;
      res_valid <= res_fire;
      if (res_fire) begin
        res_pass <= res_pass_d;
        res_tag  <= res_tag_d;
      end
      if (latch) begin
        held_cond    <= issue_cond;
        held_setflag <= issue_setflag;
        held_tag     <= issue_tag;
      end
      // Simultaneous resolve and retire leaves the count unchanged.
      if (inc && !dec && (pend_cnt != CNT_W'(PEND_MAX)))
        pend_cnt <= pend_cnt + CNT_W'(1);
      else if (dec && !inc)
        pend_cnt <= pend_cnt - CNT_W'(1);
      if (flag_wr_valid && (pend_cnt == '0))
        err_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ccr_cond_resolver.sv
// Scoreboard bench for ccr_cond_resolver: expected results are queued when an
// instruction is offered and compared when res_valid strobes.
module tb_ccr_cond_resolver;

  localparam int TAG_W = 4;

  logic             clock = 1'b0;
  logic             reset;
  logic             issue_valid, issue_ready, issue_setflag;
  logic [1:0]       issue_cond;
  logic [TAG_W-1:0] issue_tag;
  logic             ccr_carry, ccr_zero;
  logic             flag_wr_valid, flag_wr_carry, flag_wr_zero, flush;
  logic             res_valid, res_pass;
  logic [TAG_W-1:0] res_tag;
  logic [1:0]       pend_cnt;
  logic             err_underflow;

  typedef struct packed {
    logic             pass;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  ccr_cond_resolver #(.TAG_W(TAG_W), .PEND_MAX(3)) dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_cond(issue_cond),
    .issue_setflag(issue_setflag), .issue_tag(issue_tag),
    .ccr_carry(ccr_carry), .ccr_zero(ccr_zero),
    .flag_wr_valid(flag_wr_valid), .flag_wr_carry(flag_wr_carry), .flag_wr_zero(flag_wr_zero),
    .flush(flush), .res_valid(res_valid), .res_pass(res_pass), .res_tag(res_tag),
    .pend_cnt(pend_cnt), .err_underflow(err_underflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Result monitor: samples on the falling edge, away from the registering edge.
  always @(negedge clock) begin
    if (!reset && res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res_valid", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("res_pass", res_pass, e.pass);
        check("res_tag",  res_tag,  e.tag);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid   = 1'b0;
    issue_cond    = 2'b00;
    issue_setflag = 1'b0;
    issue_tag     = '0;
    flag_wr_valid = 1'b0;
    flag_wr_carry = 1'b0;
    flag_wr_zero  = 1'b0;
    flush         = 1'b0;
  endtask

  // Offer one instruction for one edge; queue the result if it resolves at issue.
  task automatic offer(input logic [1:0] cond, input logic setflag, input logic [TAG_W-1:0] tag,
                       input logic expect_now, input logic pass);
    issue_valid   = 1'b1;
    issue_cond    = cond;
    issue_setflag = setflag;
    issue_tag     = tag;
    #1;
    check("issue_ready_offer", issue_ready, 1);
    if (expect_now) exp_q.push_back('{pass: pass, tag: tag});
    tick();
    issue_valid   = 1'b0;
    issue_setflag = 1'b0;
  endtask

  task automatic flag_write(input logic c, input logic z);
    flag_wr_valid = 1'b1;
    flag_wr_carry = c;
    flag_wr_zero  = z;
    tick();
    flag_wr_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    ccr_carry = 1'b0;
    ccr_zero  = 1'b0;
    reset     = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // 1: reset state and an ALWAYS issue
    check("rst_res_valid", res_valid, 0);
    check("rst_pend_cnt",  pend_cnt, 0);
    check("rst_err",       err_underflow, 0);
    check("rst_ready",     issue_ready, 1);
    offer(2'b00, 1'b0, 4'd3, 1'b1, 1'b1);
    check("t1_pend", pend_cnt, 0);

    // 2: direct CCR reads with nothing pending
    ccr_carry = 1'b1;
    ccr_zero  = 1'b0;
    offer(2'b01, 1'b0, 4'd5, 1'b1, 1'b1);
    offer(2'b10, 1'b0, 4'd6, 1'b1, 1'b0);
    offer(2'b11, 1'b0, 4'd2, 1'b1, 1'b0);
    ccr_carry = 1'b0;
    ccr_zero  = 1'b1;
    offer(2'b01, 1'b0, 4'd8, 1'b1, 1'b0);
    offer(2'b10, 1'b0, 4'd1, 1'b1, 1'b1);
    ccr_zero  = 1'b0;

    // 3: dependent IF_ZERO stalls until the pending write retires, using the forwarded zero
    offer(2'b00, 1'b1, 4'd1, 1'b1, 1'b1);
    check("t3_pend_one", pend_cnt, 1);
    offer(2'b10, 1'b0, 4'd7, 1'b0, 1'b0);
    check("t3_wait_ready", issue_ready, 0);
    tick();
    check("t3_still_wait", issue_ready, 0);
    exp_q.push_back('{pass: 1'b1, tag: 4'd7});
    flag_write(1'b0, 1'b1);
    check("t3_pend_zero", pend_cnt, 0);
    tick();

    // 4: saturation of the in-flight counter
    offer(2'b00, 1'b1, 4'd10, 1'b1, 1'b1);
    offer(2'b00, 1'b1, 4'd11, 1'b1, 1'b1);
    offer(2'b00, 1'b1, 4'd12, 1'b1, 1'b1);
    check("t4_pend_full", pend_cnt, 3);
    issue_valid   = 1'b1;
    issue_cond    = 2'b00;
    issue_setflag = 1'b1;
    issue_tag     = 4'd13;
    #1;
    check("t4_full_ready", issue_ready, 0);
    flag_wr_valid = 1'b1;
    #1;
    check("t4_retire_ready", issue_ready, 1);
    exp_q.push_back('{pass: 1'b1, tag: 4'd13});
    tick();
    idle_inputs();
    check("t4_pend_held", pend_cnt, 3);
    repeat (3) flag_write(1'b0, 1'b0);
    check("t4_pend_drained", pend_cnt, 0);
    check("t4_no_err", err_underflow, 0);

    // 5: flush and reset while holding a stalled instruction
    offer(2'b00, 1'b1, 4'd4, 1'b1, 1'b1);
    offer(2'b01, 1'b0, 4'd9, 1'b0, 1'b0);
    check("t5_wait_ready", issue_ready, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("t5_flush_idle", issue_ready, 1);
    check("t5_flush_pend", pend_cnt, 1);
    tick();
    offer(2'b10, 1'b0, 4'd9, 1'b0, 1'b0);
    check("t5_rewait_ready", issue_ready, 0);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_res_valid", res_valid, 0);
    check("t5_rst_res_tag",   res_tag, 0);
    check("t5_rst_res_pass",  res_pass, 0);
    check("t5_rst_pend",      pend_cnt, 0);
    check("t5_rst_ready",     issue_ready, 1);
    tick();
    reset = 1'b0;
    tick();

    // 6: a flag write with nothing pending is an underflow that sticks
    flag_write(1'b1, 1'b1);
    check("t6_err_set",  err_underflow, 1);
    check("t6_pend",     pend_cnt, 0);
    repeat (2) tick();
    check("t6_err_sticky", err_underflow, 1);

    repeat (2) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
